// File: rtl/i_adap_quan_pkg.sv
// Shared types, widths and DQLN tables for the G.726 inverse adaptive quantizer family.
// The reconst() helper is the RECONST step and is reusable by the other G.726 blocks.
package i_adap_quan_pkg;

    localparam int DQLN_W = 12;
    localparam int Y_W    = 13;
    localparam int DQ_W   = 16;
    localparam int I_W    = 5;

    typedef enum logic [1:0] {
        RATE_40K = 2'b00,
        RATE_32K = 2'b01,
        RATE_24K = 2'b10,
        RATE_16K = 2'b11
    } rate_e;

    typedef struct packed {
        logic              dqs;
        logic [DQLN_W-1:0] dqln;
    } reconst_t;

    // Negative table entries are stored as 12-bit two's complement.
    function automatic logic [DQLN_W-1:0] dqln_40k(input logic [3:0] m);
        logic [DQLN_W-1:0] v;
        case (m)
            4'd0:    v = 12'h800;
            4'd1:    v = 12'hFBE;
            4'd2:    v = 12'd28;
            4'd3:    v = 12'd104;
            4'd4:    v = 12'd169;
            4'd5:    v = 12'd224;
            4'd6:    v = 12'd274;
            4'd7:    v = 12'd318;
            4'd8:    v = 12'd358;
            4'd9:    v = 12'd395;
            4'd10:   v = 12'd429;
            4'd11:   v = 12'd459;
            4'd12:   v = 12'd488;
            4'd13:   v = 12'd514;
            4'd14:   v = 12'd539;
            default: v = 12'd566;
        endcase
        return v;
    endfunction

    function automatic logic [DQLN_W-1:0] dqln_32k(input logic [2:0] m);
        logic [DQLN_W-1:0] v;
        case (m)
            3'd0:    v = 12'h800;
            3'd1:    v = 12'd4;
            3'd2:    v = 12'd135;
            3'd3:    v = 12'd213;
            3'd4:    v = 12'd273;
            3'd5:    v = 12'd323;
            3'd6:    v = 12'd373;
            default: v = 12'd425;
        endcase
        return v;
    endfunction

    function automatic logic [DQLN_W-1:0] dqln_24k(input logic [1:0] m);
        logic [DQLN_W-1:0] v;
        case (m)
            2'd0:    v = 12'h800;
            2'd1:    v = 12'd135;
            2'd2:    v = 12'd273;
            default: v = 12'd373;
        endcase
        return v;
    endfunction

    function automatic logic [DQLN_W-1:0] dqln_16k(input logic m);
        return m ? 12'd365 : 12'd116;
    endfunction

    // Sign is the MSB of the active width; magnitude is the ones-complement when negative.
    function automatic reconst_t reconst(input rate_e rate, input logic [I_W-1:0] i);
        reconst_t r;
        r = '0;
        case (rate)
            RATE_40K: begin
                r.dqs  = i[4];
                r.dqln = dqln_40k(i[4] ? ~i[3:0] : i[3:0]);
            end
            RATE_32K: begin
                r.dqs  = i[3];
                r.dqln = dqln_32k(i[3] ? ~i[2:0] : i[2:0]);
            end
            RATE_24K: begin
                r.dqs  = i[2];
                r.dqln = dqln_24k(i[2] ? ~i[1:0] : i[1:0]);
            end
            default: begin
                r.dqs  = i[1];
                r.dqln = dqln_16k((i[1:0] == 2'b01) || (i[1:0] == 2'b10));
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/i_adap_quan_antilog.sv
// G.726 ANTILOG: converts the 12-bit log-domain DQL into the 15-bit linear magnitude.
// Purely combinational so other G.726 blocks can drop it into their own pipelines.
module i_adap_quan_antilog
    import i_adap_quan_pkg::*;
(
    input  logic [DQLN_W-1:0] dql,
    output logic [DQ_W-2:0]   dqmag
);

    logic            ds;
    logic [3:0]      dex;
    logic [7:0]      dqt;
    logic [3:0]      shamt;
    logic [DQ_W-2:0] shifted;

    // (DQT << 7) >> (14 - DEX) is computed as (DQT << 8) >> (15 - DEX) so DEX = 15 stays a right shift.
    always_comb begin
        ds      = dql[11];
        dex     = dql[10:7];
        dqt     = {1'b1, dql[6:0]};
        shamt   = 4'd15 - dex;
        shifted = (DQ_W-1)'({dqt, 8'b0} >> shamt);
        dqmag   = ds ? '0 : shifted;
    end

endmodule

// File: rtl/i_adap_quan_mc.sv
// Multi-channel, multi-rate G.726 inverse adaptive quantizer: RECONST -> ADDA -> ANTILOG, 3 stages.
// Optional per-channel output counters are enabled with `define I_ADAP_QUAN_MC_CNT_EN.
module i_adap_quan_mc
    import i_adap_quan_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [1:0]        in_rate,
    input  logic [I_W-1:0]    in_i,
    input  logic [Y_W-1:0]    in_y,
`ifdef I_ADAP_QUAN_MC_CNT_EN
    input  logic [CH_W-1:0]   cnt_ch,
    output logic [15:0]       cnt_val,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [DQ_W-1:0]   out_dq
);

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    reconst_t rc;
    always_comb begin
        rc = reconst(rate_e'(in_rate), in_i);
    end

    logic              s1_valid;
    logic [CH_W-1:0]   s1_ch;
    logic              s1_dqs;
    logic [DQLN_W-1:0] s1_dqln;
    logic [Y_W-1:0]    s1_y;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_ch    <= '0;
            s1_dqs   <= 1'b0;
            s1_dqln  <= '0;
            s1_y     <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_ch   <= in_ch;
                s1_dqs  <= rc.dqs;
                s1_dqln <= rc.dqln;
                s1_y    <= in_y;
            end
        end
    end

    logic              s2_valid;
    logic [CH_W-1:0]   s2_ch;
    logic              s2_dqs;
    logic [DQLN_W-1:0] s2_dql;

    // ADDA wraps modulo 4096; no saturation.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s2_valid <= 1'b0;
            s2_ch    <= '0;
            s2_dqs   <= 1'b0;
            s2_dql   <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_ch  <= s1_ch;
                s2_dqs <= s1_dqs;
                s2_dql <= s1_dqln + DQLN_W'(s1_y >> 2);
            end
        end
    end

    logic [DQ_W-2:0] dqmag;

    i_adap_quan_antilog u_antilog (
        .dql   (s2_dql),
        .dqmag (dqmag)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_dq    <= '0;
        end else if (adv) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_ch <= s2_ch;
                out_dq <= {s2_dqs, dqmag};
            end
        end
    end

`ifdef I_ADAP_QUAN_MC_CNT_EN
    logic [15:0] cnt_q [NUM_CH];

    // The read uses the pre-update array, so a same-cycle count shows the old value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                cnt_q[k] <= '0;
            end
            cnt_val <= '0;
        end else begin
            if (out_valid && out_ready && (int'(out_ch) < NUM_CH)) begin
                cnt_q[out_ch] <= cnt_q[out_ch] + 16'd1;
            end
            cnt_val <= (int'(cnt_ch) < NUM_CH) ? cnt_q[cnt_ch] : '0;
        end
    end
`endif

endmodule

// File: tb/tb_i_adap_quan_mc.sv
// Directed self-checking bench for i_adap_quan_mc: reset, table vectors, stalled burst, flush,
// and (with I_ADAP_QUAN_MC_CNT_EN defined) the per-channel output counters.
module tb_i_adap_quan_mc;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int NV     = 18;
    localparam int NB     = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [CH_W-1:0] in_ch = '0;
    logic [1:0]      in_rate = '0;
    logic [4:0]      in_i = '0;
    logic [12:0]     in_y = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [CH_W-1:0] out_ch;
    logic [15:0]     out_dq;
`ifdef I_ADAP_QUAN_MC_CNT_EN
    logic [CH_W-1:0] cnt_ch = '0;
    logic [15:0]     cnt_val;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [CH_W-1:0] ch;
        logic [1:0]      rate;
        logic [4:0]      i;
        logic [12:0]     y;
        logic [15:0]     dq;
    } vec_t;

    vec_t vecs [NV];
    int   burst [NB];

    i_adap_quan_mc #(.NUM_CH(NUM_CH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .in_rate   (in_rate),
        .in_i      (in_i),
        .in_y      (in_y),
`ifdef I_ADAP_QUAN_MC_CNT_EN
        .cnt_ch    (cnt_ch),
        .cnt_val   (cnt_val),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_dq    (out_dq)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        in_valid = 1'b1;
        in_ch    = v.ch;
        in_rate  = v.rate;
        in_i     = v.i;
        in_y     = v.y;
    endtask

    // One isolated sample through an idle pipe; checks latency, tag and DQ.
    task automatic runSingle(input string tag, input vec_t v);
        int lat;
        @(posedge clk); #1;
        out_ready = 1'b1;
        applyStimulus(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({tag, "_lat"}, lat, 3);
        checkOutput({tag, "_ch"}, out_ch, v.ch);
        checkOutput({tag, "_dq"}, out_dq, v.dq);
    endtask

    initial begin
        int sent, got, outCount;
        logic held, sawBlock;
        logic [15:0] heldDq;
        logic [CH_W-1:0] heldCh;

        // rate: 0=40k 1=32k 2=24k 3=16k
        vecs = '{
            '{2'd0, 2'd1, 5'd4,  13'd544,  16'h0009},
            '{2'd1, 2'd1, 5'd11, 13'd544,  16'h8009},
            '{2'd2, 2'd1, 5'd0,  13'd544,  16'h0000},
            '{2'd3, 2'd0, 5'd15, 13'd5120, 16'h5B00},
            '{2'd0, 2'd3, 5'd1,  13'd544,  16'h000F},
            '{2'd1, 2'd3, 5'd2,  13'd544,  16'h800F},
            '{2'd2, 2'd2, 5'd3,  13'd544,  16'h000F},
            '{2'd3, 2'd2, 5'd1,  13'd544,  16'h0004},
            '{2'd0, 2'd0, 5'd16, 13'd5120, 16'hDB00},
            '{2'd1, 2'd0, 5'd31, 13'd5120, 16'h8000},
            '{2'd2, 2'd0, 5'd1,  13'd1024, 16'h0002},
            '{2'd3, 2'd0, 5'd15, 13'd8191, 16'h0000},
            '{2'd0, 2'd1, 5'd20, 13'd544,  16'h0009},
            '{2'd1, 2'd3, 5'd29, 13'd544,  16'h000F},
            '{2'd2, 2'd2, 5'd6,  13'd544,  16'h8004},
            '{2'd3, 2'd2, 5'd4,  13'd544,  16'h800F},
            '{2'd0, 2'd1, 5'd7,  13'd0,    16'h000A},
            '{2'd1, 2'd1, 5'd1,  13'd0,    16'h0001}
        };
        burst = '{0, 9, 6, 3, 4, 1, 10, 7};

        $display("[TB] reset");
        reset = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_dq", out_dq, 0);
        checkOutput("rst_out_ch", out_ch, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_in_ready", in_ready, 1);

        $display("[TB] directed vectors");
        for (int k = 0; k < NV; k++) begin
            runSingle($sformatf("vec%0d", k), vecs[k]);
        end
        @(posedge clk); #1;

        $display("[TB] burst with stall");
        sent = 0; got = 0; held = 1'b0; sawBlock = 1'b0; heldDq = '0; heldCh = '0;
        for (int cyc = 0; cyc < 60 && got < NB; cyc++) begin
            @(posedge clk); #1;
            out_ready = (cyc < 4 || cyc > 8);
            if (sent < NB) applyStimulus(vecs[burst[sent]]);
            else in_valid = 1'b0;
            #1;
            if (held) begin
                checkOutput("stall_dq_stable", out_dq, heldDq);
                checkOutput("stall_ch_stable", out_ch, heldCh);
            end
            held = out_valid && !out_ready;
            heldDq = out_dq;
            heldCh = out_ch;
            if (held) begin
                checkOutput("stall_in_ready", in_ready, 0);
                sawBlock = 1'b1;
            end
            if (out_valid && out_ready) begin
                checkOutput($sformatf("burst%0d_ch", got), out_ch, vecs[burst[got]].ch);
                checkOutput($sformatf("burst%0d_dq", got), out_dq, vecs[burst[got]].dq);
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        checkOutput("burst_count", got, NB);
        checkOutput("burst_stall_seen", sawBlock, 1);
        outCount = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) outCount++;
        end
        checkOutput("burst_no_extra", outCount, 0);

        $display("[TB] reset flush");
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(vecs[k + 3]);
            #1;
            checkOutput($sformatf("flush_accept%0d", k), in_ready, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checkOutput("flush_full", out_valid, 1);
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("flush_out_valid", out_valid, 0);
        reset = 1'b1;
        out_ready = 1'b1;
        outCount = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) outCount++;
        end
        checkOutput("flush_none_emitted", outCount, 0);
        checkOutput("flush_in_ready", in_ready, 1);
        runSingle("post_flush", vecs[8]);

`ifdef I_ADAP_QUAN_MC_CNT_EN
        $display("[TB] counters");
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        sent = 0;
        for (int cyc = 0; cyc < 200 && sent < 10; cyc++) begin
            @(posedge clk); #1;
            out_ready = (cyc % 3 != 1);
            applyStimulus('{(sent % 3 == 2) ? 2'd0 : 2'd2, 2'd1, 5'd4, 13'd544, 16'h0009});
            #1;
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        cnt_ch = 2'd2;
        @(posedge clk); #1;
        checkOutput("cnt_ch2", cnt_val, 7);
        cnt_ch = 2'd0;
        @(posedge clk); #1;
        checkOutput("cnt_ch0", cnt_val, 3);
        cnt_ch = 2'd3;
        @(posedge clk); #1;
        checkOutput("cnt_ch3", cnt_val, 0);
        applyStimulus('{2'd1, 2'd3, 5'd1, 13'd544, 16'h000F});
        repeat (65536) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        cnt_ch = 2'd1;
        @(posedge clk); #1;
        checkOutput("cnt_ch1_wrap", cnt_val, 0);
        cnt_ch = 2'd2;
        @(posedge clk); #1;
        checkOutput("cnt_ch2_kept", cnt_val, 7);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i_adap_quan_mc.md
Name: i_adap_quan_mc

Overview:
Multi-channel, multi-rate G.726 inverse adaptive quantizer. Per sample it maps the ADPCM codeword I and scale factor Y to the quantized difference DQ, using RECONST, then ADDA, then ANTILOG.
- Supports 40, 32, 24 and 16 kbit/s, selected per sample.
- Channels are time-interleaved; the caller supplies each channel's Y.
- 3-stage pipeline with valid/ready handshakes; sits between the codeword demux and the per-channel reconstruction/predictor blocks.

Parameters:
NUM_CH, 4, number of interleaved channels (≥1).
CH_W, $clog2(NUM_CH) (minimum 1), width of the channel tag.

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  synchronous, active-low reset.
in_valid  in  1  input sample valid.
in_ready  out  1  block can accept a sample.
in_ch  in  CH_W  channel tag.
in_rate  in  2  00=40k (5-bit I), 01=32k (4-bit), 10=24k (3-bit), 11=16k (2-bit).
in_i  in  5  codeword, right-aligned; unused MSBs ignored.
in_y  in  13  scale factor Y, unsigned.
out_valid  out  1  DQ valid.
out_ready  in  1  downstream accepts.
out_ch  out  CH_W  channel tag carried through the pipe.
out_dq  out  16  DQ in sign-magnitude: bit15 = sign, bits 14:0 = magnitude.

Behaviour:
- Reset (reset=0 at clk edge): all stage valids = 0, out_valid = 0, out_ch = 0, out_dq = 0. in_ready = 1 in the cycle after reset is released.
- Reset mid-operation flushes all in-flight samples; nothing is emitted afterwards.
- Pipeline advance: adv = !out_valid || out_ready. in_ready = adv.
  - Input accepted when in_valid && in_ready.
  - All stages shift together on adv. When !adv, every stage register holds.
  - Bubbles propagate as valid = 0.
  - Latency is 3 cycles from accept to out_valid when never stalled. Throughput is 1 sample per cycle.
  - out_dq and out_ch stay stable while out_valid && !out_ready.
- S1, RECONST:
  - DQS = sign bit of I (MSB of the active width).
  - Magnitude index m = I when the sign bit is 0, else ones-complement of I within the active width.
  - 16k is special: m = 1 for I ∈ {1,2}, else 0.
  - DQLN is a 12-bit two's-complement table lookup per rate:
    - 40k, m = 0..15: -2048, -66, 28, 104, 169, 224, 274, 318, 358, 395, 429, 459, 488, 514, 539, 566.
    - 32k, m = 0..7: -2048, 4, 135, 213, 273, 323, 373, 425.
    - 24k, m = 0..3: -2048, 135, 273, 373.
    - 16k, m = 0..1: 116, 365.
- S2, ADDA: DQL = (DQLN + (Y >> 2)) mod 4096, 12 bits, wrap with no saturation.
- S3, ANTILOG:
  - DS = DQL[11]; DEX = DQL[10:7]; DMN = DQL[6:0]; DQT = {1, DMN} (8 bits).
  - DQMAG = DS ? 0 : ((DQT << 7) >> (14 − DEX)), truncated to 15 bits.
  - out_dq = {DQS, DQMAG}. A negative zero (DQS=1, DQMAG=0) is output as-is.
- in_rate is sampled per sample; a rate change between consecutive samples needs no idle cycle.

Optional Feature:
I_ADAP_QUAN_MC_CNT_EN
- Defined:
  - Adds ports cnt_ch (in, CH_W) and cnt_val (out, 16).
  - Keeps a 16-bit counter per channel, incremented on each output handshake (out_valid && out_ready) for out_ch; counters wrap at 0xFFFF → 0.
  - cnt_val is registered and reflects counter[cnt_ch] one cycle after cnt_ch is presented. If a count lands in the same cycle it is read, cnt_val shows the pre-increment value.
  - All counters and cnt_val are cleared by reset.
- Undefined: the ports and counters are absent; the datapath is identical.

Decomposition:
- Package i_adap_quan_pkg holds:
  - rate encoding constants;
  - the four DQLN tables as constant functions;
  - width localparams (DQLN_W=12, Y_W=13, DQ_W=16).
- Sub-module i_adap_quan_antilog: combinational, DQL → DQMAG. It is instantiated in S3 and is reusable by the other G.726 blocks.

Test Plan:
- 32k, I=4, Y=544 → DQL=409, out_dq=0x0009 three cycles later. Same with I=11 → out_dq=0x8009.
- 32k, I=0, Y=544 → DQL=0x888, DS=1 → out_dq=0x0000.
- 40k, I=15, Y=5120 → DQL=1846, DEX=14 → out_dq=0x5B00. 16k, I=1, Y=544 → out_dq=0x000F.
- Back-to-back samples on channels 0,1,2,3 at alternating rates, with out_ready held low for 5 cycles mid-burst:
  - in_ready drops once the pipe is full;
  - outputs keep order and tags 0..3 with no loss or duplicates;
  - out_dq is stable during the stall.
- Reset asserted for 1 cycle with 3 samples in flight → out_valid=0 the next cycle, none of them ever emitted, in_ready=1 after release.
- CNT_EN build: 7 samples on ch2 and 3 on ch0 (with stalls) → cnt_ch=2 gives cnt_val=7, cnt_ch=0 gives 3. After 65536 samples on ch1, its count is 0.
